// File: rtl/transform_sequencer_if.sv
// transform_sequencer_if
// Output pair stream between the transform sequencer and its consumer
// (display or UART formatter).
//   out_valid  pair valid (master -> slave)
//   out_ready  consumer accepts the pair (slave -> master)
//   out_lhs    mem word [15:8]
//   out_rhs    mem word [7:0]
//   out_last   final pair of a line, qualified by out_valid
interface transform_sequencer_if;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_lhs;
  logic [7:0] out_rhs;
  logic       out_last;

  modport master (
    output out_valid, out_lhs, out_rhs, out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_lhs, out_rhs, out_last,
    output out_ready
  );
endinterface

// File: rtl/transform_sequencer.sv
// transform_sequencer
// Plays back one transform line from character memory as (lhs, rhs) pairs.
// Looks up the line's {length, start} descriptor through the external
// mapper, walks the memory addresses (8-bit wrap) and hands each word to
// the consumer over a valid/ready handshake.
//
// Ports:
//   clk, rst_n   clock, async active-low reset
//   start        playback request, sampled in IDLE only
//   line_sel     line index to play
//   busy         high whenever not IDLE
//   map_line     registered line index to the combinational mapper
//   map_ptr      mapper result: [15:8] length, [7:0] start address
//   mem_addr     registered memory address, 8'hFF when idle
//   mem_dout     registered memory read data (one cycle after mem_addr)
//   done         one-cycle pulse at the end of every playback
//   err          one-cycle pulse with done for an out-of-range line
//   pair_bus     output pair stream (master side)
//
// Build option: define TRANSFORM_SEQ_AUTO_ADVANCE_EN to continue through
// all following lines after the selected one, with a single done at the end.
//
// state   | meaning
// IDLE    | waiting for start
// MAP     | latch length/base from the mapper, first address out
// ISSUE   | address held while memory samples it
// WAIT    | capture read data into the pair registers
// PRESENT | pair valid, held until out_ready
// DONE    | done (and err) pulse, back to IDLE
module transform_sequencer #(
  parameter int unsigned NUM_LINES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  line_sel,
  output logic        busy,
  output logic [7:0]  map_line,
  input  logic [15:0] map_ptr,
  output logic [7:0]  mem_addr,
  input  logic [15:0] mem_dout,
  output logic        done,
  output logic        err,
  transform_sequencer_if.master pair_bus
);

  typedef enum logic [2:0] {
    IDLE, MAP, ISSUE, WAIT, PRESENT, DONE
  } state_t;

  state_t     state;
  logic [7:0] len;
  logic [7:0] base;
  logic [7:0] idx;
  logic       out_valid;
  logic [7:0] out_lhs;
  logic [7:0] out_rhs;
  logic       out_last;

`ifdef TRANSFORM_SEQ_AUTO_ADVANCE_EN
  // 9 bits so line 255 + 1 cannot alias back to 0
  logic [8:0] next_line;
  assign next_line = {1'b0, map_line} + 9'd1;
`endif

  assign busy               = (state != IDLE);
  assign pair_bus.out_valid = out_valid;
  assign pair_bus.out_lhs   = out_lhs;
  assign pair_bus.out_rhs   = out_rhs;
  assign pair_bus.out_last  = out_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      map_line  <= 8'd0;
      mem_addr  <= 8'hFF;
      len       <= 8'd0;
      base      <= 8'd0;
      idx       <= 8'd0;
      out_valid <= 1'b0;
      out_lhs   <= 8'd0;
      out_rhs   <= 8'd0;
      out_last  <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            map_line <= line_sel;
            if ({24'd0, line_sel} >= NUM_LINES) begin
              done  <= 1'b1;
              err   <= 1'b1;
              state <= DONE;
            end else begin
              state <= MAP;
            end
          end
        end
        MAP: begin
          len      <= map_ptr[15:8];
          base     <= map_ptr[7:0];
          idx      <= 8'd0;
          mem_addr <= map_ptr[7:0];
          if (map_ptr[15:8] == 8'd0) begin
            done     <= 1'b1;
            mem_addr <= 8'hFF;
            state    <= DONE;
          end else begin
            state <= ISSUE;
          end
        end
        ISSUE: state <= WAIT;
        WAIT: begin
          out_lhs   <= mem_dout[15:8];
          out_rhs   <= mem_dout[7:0];
          out_last  <= (idx == len - 8'd1);
          out_valid <= 1'b1;
          state     <= PRESENT;
        end
        PRESENT: begin
          if (pair_bus.out_ready) begin
            out_valid <= 1'b0;
            if (out_last) begin
`ifdef TRANSFORM_SEQ_AUTO_ADVANCE_EN
              if ({23'd0, next_line} < NUM_LINES) begin
                map_line <= next_line[7:0];
                state    <= MAP;
              end else begin
                done     <= 1'b1;
                mem_addr <= 8'hFF;
                state    <= DONE;
              end
`else
              done     <= 1'b1;
              mem_addr <= 8'hFF;
              state    <= DONE;
`endif
            end else begin
              idx      <= idx + 8'd1;
              mem_addr <= base + idx + 8'd1;
              state    <= ISSUE;
            end
          end
        end
        DONE: begin
          mem_addr <= 8'hFF;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_transform_sequencer.sv
module tb_transform_sequencer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  line_sel = 8'd0;
  logic        busy;
  logic [7:0]  map_line;
  logic [15:0] map_ptr;
  logic [7:0]  mem_addr;
  logic [15:0] mem_dout = 16'd0;
  logic        done;
  logic        err;

  transform_sequencer_if bus();

  transform_sequencer #(.NUM_LINES(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .line_sel (line_sel),
    .busy     (busy),
    .map_line (map_line),
    .map_ptr  (map_ptr),
    .mem_addr (mem_addr),
    .mem_dout (mem_dout),
    .done     (done),
    .err      (err),
    .pair_bus (bus)
  );

  always #5 clk = ~clk;

  // memory and line mapper models
  logic [15:0] mem [256];
  logic [15:0] map_tbl [2];
  always @(posedge clk) mem_dout <= mem[mem_addr];
  assign map_ptr = (map_line < 8'd2) ? map_tbl[map_line[0]] : 16'h0000;

  typedef struct {
    logic [7:0]  addr;
    logic [15:0] data;
    bit          last;
  } pair_t;

  pair_t       exp_q[$];
  pair_t       p;
  logic [15:0] log_data[$];
  logic [7:0]  log_addr[$];
  bit          log_last[$];
  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  int          exp_done_at = -1;
  int          exp_valid_at = -1;
  bit          exp_err = 0;
  bit          prev_valid = 0;
  bit          done_seen = 0;
  int          pair_idx = 0;
  int          stall_pair = -1;
  int          stall_left = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // consumer: ready high except for a programmed stall on one pair
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (bus.out_valid && pair_idx == stall_pair && stall_left > 0) begin
        bus.out_ready = 1'b0;
        stall_left--;
      end else begin
        bus.out_ready = 1'b1;
      end
    end
  end

  // compare process: every cycle out of reset
  always @(negedge clk) begin
    if (rst_n) begin
      check("done", done, cyc == exp_done_at);
      check("err", err, (cyc == exp_done_at) && exp_err);
      if (done) done_seen = 1;
      if (!busy) begin
        check("idle_valid", bus.out_valid, 0);
        check("idle_addr", mem_addr, 8'hFF);
      end
      if (bus.out_valid) begin
        if (!prev_valid) check("valid_latency", cyc, exp_valid_at);
        if (exp_q.size() == 0) begin
          check("unexpected_pair", bus.out_valid, 0);
        end else begin
          check("lhs", bus.out_lhs, exp_q[0].data[15:8]);
          check("rhs", bus.out_rhs, exp_q[0].data[7:0]);
          check("last", bus.out_last, exp_q[0].last);
          check("addr_held", mem_addr, exp_q[0].addr);
          if (bus.out_ready) begin
            p = exp_q.pop_front();
            log_data.push_back({bus.out_lhs, bus.out_rhs});
            log_addr.push_back(mem_addr);
            log_last.push_back(bus.out_last);
            pair_idx++;
            if (exp_q.size() == 0) exp_done_at = cyc + 1;
            else exp_valid_at = cyc + (p.last ? 4 : 3);
          end
        end
      end
      prev_valid = bus.out_valid;
    end
  end

  // Expected pairs straight from the descriptor table and memory contents.
  task automatic build_expect(input logic [7:0] line, input int s);
    int l;
    logic [7:0] len, st;
    exp_q.delete();
    exp_err = 0;
    exp_done_at = -1;
    exp_valid_at = s + 4;
    if (line >= 8'd2) begin
      exp_err = 1;
      exp_done_at = s + 1;
      return;
    end
    if (map_tbl[line[0]][15:8] == 8'd0) begin
      exp_done_at = s + 2;
      return;
    end
    l = int'(line);
    do begin
      len = map_tbl[l][15:8];
      st  = map_tbl[l][7:0];
      for (int i = 0; i < int'(len); i++) begin
        pair_t e;
        e.addr = st + 8'(i);
        e.data = mem[e.addr];
        e.last = (i == int'(len) - 1);
        exp_q.push_back(e);
      end
      l++;
`ifdef TRANSFORM_SEQ_AUTO_ADVANCE_EN
    end while (l < 2);
`else
    end while (0);
`endif
  endtask

  task automatic play(input logic [7:0] line, input int poke);
    log_data.delete();
    log_addr.delete();
    log_last.delete();
    pair_idx = 0;
    done_seen = 0;
    @(posedge clk);
    #1;
    start = 1'b1;
    line_sel = line;
    build_expect(line, cyc);
    @(posedge clk);
    #1;
    start = 1'b0;
    if (poke > 0) begin
      repeat (poke) @(posedge clk);
      #1;
      start = 1'b1;
      line_sel = 8'd1;
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      #1;
      if (done_seen) break;
    end
    check("done_seen", done_seen, 1);
    check("pairs_left", exp_q.size(), 0);
    @(negedge clk);
    #1;
    check("busy_drop", busy, 0);
  endtask

  task automatic check_line0_log();
    check("pair1", log_data[0], 16'h3131);
    check("pair2", log_data[1], 16'h6D73);
    check("pair3", log_data[2], 16'h7320);
    check("last1", log_last[0], 0);
    check("last3", log_last[2], 1);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = {8'(i) ^ 8'h5A, 8'(i)};
    mem[0] = 16'h3131;
    mem[1] = 16'h6D73;
    mem[2] = 16'h7320;
    map_tbl[0] = 16'h0300;
    map_tbl[1] = 16'h0503;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_map_line", map_line, 0);
    check("rst_mem_addr", mem_addr, 8'hFF);
    check("rst_valid", bus.out_valid, 0);
    check("rst_lhs", bus.out_lhs, 0);
    check("rst_rhs", bus.out_rhs, 0);
    check("rst_last", bus.out_last, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    #2 rst_n = 1'b1;

    // single line
    play(8'd0, 0);
    check_line0_log();
`ifdef TRANSFORM_SEQ_AUTO_ADVANCE_EN
    check("auto_count", log_data.size(), 8);
    check("auto_last3", log_last[2], 1);
    check("auto_last7", log_last[6], 0);
    check("auto_last8", log_last[7], 1);
    for (int i = 0; i < 8; i++) check("auto_addr", log_addr[i], 8'(i));
`else
    check("pair_count", log_data.size(), 3);
    check("last2", log_last[1], 0);
`endif

    // backpressure on pair 2
    stall_pair = 1;
    stall_left = 5;
    play(8'd0, 0);
    check_line0_log();
    check("stall_used", stall_left, 0);
    stall_pair = -1;

    // empty line
    map_tbl[0] = 16'h0012;
    play(8'd0, 0);
    check("empty_count", log_data.size(), 0);

    // out-of-range line
    play(8'd7, 0);
    check("err_count", log_data.size(), 0);

    // start while busy is ignored
    map_tbl[0] = 16'h0300;
    play(8'd0, 2);
    check_line0_log();

    // address wrap
    map_tbl[0] = 16'h03FE;
    play(8'd0, 0);
    check("wrap_a0", log_addr[0], 8'hFE);
    check("wrap_a1", log_addr[1], 8'hFF);
    check("wrap_a2", log_addr[2], 8'h00);
    check("wrap_d2", log_data[2], 16'h3131);

    // line 1 alone
    map_tbl[0] = 16'h0300;
    play(8'd1, 0);
    check("line1_first", log_addr[0], 8'h03);

    // reset while pair 2 is presented
    stall_pair = 1;
    stall_left = 20;
    pair_idx = 0;
    @(posedge clk);
    #1;
    start = 1'b1;
    line_sel = 8'd0;
    build_expect(8'd0, cyc);
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      #1;
      if (pair_idx == 1 && bus.out_valid) break;
    end
    check("reach_pair2", (pair_idx == 1) && bus.out_valid, 1);
    #1 rst_n = 1'b0;
    exp_q.delete();
    exp_done_at = -1;
    prev_valid = 0;
    stall_left = 0;
    stall_pair = -1;
    #1;
    check("mid_rst_valid", bus.out_valid, 0);
    check("mid_rst_addr", mem_addr, 8'hFF);
    check("mid_rst_busy", busy, 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    play(8'd0, 0);
    check_line0_log();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/transform_sequencer.md
# transform_sequencer

Plays back one transform line from character memory as a stream of (lhs, rhs) ASCII pairs. The block sits between the line mapper and the character memory. It takes a line index, looks up that line's {length, start} descriptor, and walks the memory addresses. It then presents each 16-bit word to a downstream consumer (display or UART formatter) over a valid/ready handshake.

## Interface
- NUM_LINES, 2: number of valid line indices; any line_sel ≥ NUM_LINES is an error.
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request playback of line_sel; sampled in IDLE only.
- line_sel  in  8  line index to play.
- busy  out  1  high whenever state ≠ IDLE.
- map_line  out  8  registered line index, driven to the combinational line mapper.
- map_ptr  in  16  mapper result: [15:8] = length, [7:0] = start address.
- mem_addr  out  8  registered character-memory address; idle value 8'hFF.
- mem_dout  in  16  memory read data; registered, valid one cycle after the memory samples mem_addr.
- out_valid  out  1  output pair valid.
- out_ready  in  1  consumer accepts the pair.
- out_lhs  out  8  mem word [15:8].
- out_rhs  out  8  mem word [7:0].
- out_last  out  1  high with out_valid on the final pair of a line.
- done  out  1  one-cycle pulse at the end of each playback, including error and empty cases.
- err  out  1  one-cycle pulse together with done when line_sel was out of range.

## Operation
- States: IDLE, MAP, ISSUE, WAIT, PRESENT, DONE.
- IDLE: when start=1, latch map_line<=line_sel and go to MAP. If line_sel ≥ NUM_LINES, set an error flag and go to DONE instead.
- MAP: latch len<=map_ptr[15:8], base<=map_ptr[7:0], idx<=0, mem_addr<=map_ptr[7:0].
  - If len==0, go to DONE with no pairs emitted.
  - Otherwise go to ISSUE.
- ISSUE: mem_addr is held so the memory can sample it. Go to WAIT.
- WAIT: capture mem_dout into out_lhs/out_rhs. Set out_last = (idx == len-1). Go to PRESENT.
- PRESENT: out_valid=1; data is held stable until out_ready.
  - On a handshake with out_last=1, go to DONE.
  - On any other handshake: idx<=idx+1, mem_addr<=base+idx+1, go to ISSUE.
- DONE: done=1 (and err if flagged) for one cycle, mem_addr<=8'hFF, then go to IDLE.
- Address arithmetic is 8-bit modulo 256: a start of 8'hFE with length 3 reads FE, FF, 00.
- idx is 8 bits; a length of 255 is legal.
- start is ignored while busy; there is no queueing.
- out_valid never drops without a handshake except on reset.

## Timing
- Reset values: busy=0, map_line=0, mem_addr=8'hFF, out_valid=0, out_lhs=0, out_rhs=0, out_last=0, done=0, err=0, state=IDLE.
- Reset takes effect immediately on rst_n falling, mid-playback included. A pending pair is dropped.
- Counting the start-sample cycle as cycle 0: MAP is cycle 1, ISSUE cycle 2, WAIT cycle 3, and the first out_valid is in cycle 4.
- Every following pair appears 3 cycles after the preceding handshake cycle (ISSUE, WAIT, PRESENT). Peak throughput is one pair per 3 cycles.
- done is asserted the cycle after the final handshake. busy drops the cycle after that, and start is accepted from that cycle on.
- For len==0, done is asserted in cycle 2. For an out-of-range line, done and err are asserted in cycle 1.

## Configuration
- TRANSFORM_SEQ_AUTO_ADVANCE_EN
  - Defined: after the last pair of line n, if n+1 < NUM_LINES, the sequencer skips DONE, sets map_line<=n+1 and enters MAP directly. done pulses only after line NUM_LINES-1 completes. out_last still marks the end of each line.
  - Undefined: exactly one line is played per start.

## Test plan
- Single line: memory model 0:3131, 1:6D73, 2:7320, map_ptr=16'h0300, start line 0. Required: three pairs 31/31, 6D/73, 73/20 with out_valid first in cycle 4. out_last only on the third pair. done in the cycle after the third handshake.
- Backpressure: same line with out_ready held low for 5 cycles on pair 2. Required: out_lhs/out_rhs/out_valid stay stable throughout, mem_addr does not advance, and all pairs arrive in order.
- Edge cases:
  - map_ptr=16'h00xx: done in cycle 2, no out_valid.
  - line_sel=8'd7 with NUM_LINES=2: done=err=1 in cycle 1.
  - start while busy: ignored.
- Wrap-around: map_ptr=16'h03FE. Required: mem_addr sequence FE, FF, 00; three pairs emitted.
- Reset mid-op: drop rst_n during PRESENT of pair 2. Required: out_valid=0 and mem_addr=FF immediately. After release, a fresh start replays from pair 1.
- Auto-advance (macro defined): line 0 ptr 0300, line 1 ptr 0503. Required: 8 pairs from addresses 0–7, out_last on pairs 3 and 8, a single done after pair 8.
